// File: rtl/template_stream_gen.sv
// rtl/template_stream_gen.sv - known-answer bitstream source for the non-overlapping template test path
//
// Emits one frame of N blocks of M bits, one bit per clock. In every block the
// template B occupies the first TM bits of the first cnt_lat 8-bit slots, and all
// other bits are filler.
//
// Build option: TSG_LFSR_FILL_EN
//   defined   - filler comes from a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1),
//               reloaded with SEED at every frame start
//   undefined - filler is constant 0 and no LFSR exists
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   start       in   frame request, sampled in IDLE or on the last bit of a frame
//   inject_cnt  in   templates per block, latched at frame start, saturates to M/8
//   rand_bit    out  serial bitstream (registered)
//   valid       out  rand_bit carries a frame bit
//   block_start out  first bit of each block
//   frame_done  out  last bit of the frame
//   busy        out  from the cycle after an accepted start through the last bit
module template_stream_gen #(
    parameter int            N    = 8,
    parameter int            M    = 256,
    parameter int            TM   = 4,
    parameter logic [TM-1:0] B    = 4'b1100,
    parameter logic [15:0]   SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] inject_cnt,
    output logic       rand_bit,
    output logic       valid,
    output logic       block_start,
    output logic       frame_done,
    output logic       busy
);
    localparam int SLOTS = M / 8;
    localparam int BW    = $clog2(M);
    localparam int KW    = (N > 1) ? $clog2(N) : 1;
    localparam int CW    = $clog2(SLOTS + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bit_idx_q, bit_idx_d;
    logic [KW-1:0] blk_idx_q, blk_idx_d;
    logic [CW-1:0] cnt_lat_q, cnt_lat_d;
    logic          rand_q, rand_d;
    logic          valid_q, valid_d;
    logic          block_start_q, block_start_d;
    logic          frame_done_q, frame_done_d;
    logic          busy_q, busy_d;

    logic [CW-1:0] cnt_sat;
    logic [CW-1:0] cnt_sel;
    logic [31:0]   slot_w;
    logic [31:0]   cnt_w;
    logic [TM-1:0] b_shift;
    logic          emit;
    logic          restart;
    logic          last_bit;
    logic          in_tmpl;
    logic          tmpl_bit;
    logic          fill_bit;

    always_comb begin
        if (32'(inject_cnt) > 32'(SLOTS)) begin
            cnt_sat = CW'(SLOTS);
        end else begin
            cnt_sat = CW'(inject_cnt);
        end
    end

    // frame_done_q marks the cycle showing the last bit; start on that cycle chains
    // a new frame with no gap, otherwise the next edge returns to IDLE.
    assign restart  = (state_q == RUN) && frame_done_q;
    assign emit     = (state_q == RUN) && !(frame_done_q && !start);
    assign last_bit = (bit_idx_q == BW'(M - 1)) && (blk_idx_q == KW'(N - 1));

    // A chained frame must use the freshly latched count for its very first bit.
    assign cnt_sel  = restart ? cnt_sat : cnt_lat_q;
    assign slot_w   = 32'(bit_idx_q[BW-1:3]);
    assign cnt_w    = 32'(cnt_sel);
    assign in_tmpl  = (slot_w < cnt_w) && (bit_idx_q[2:0] < 3'(TM));
    assign b_shift  = B << bit_idx_q[2:0];
    assign tmpl_bit = b_shift[TM-1];

`ifdef TSG_LFSR_FILL_EN
    logic [15:0] lfsr_q, lfsr_d, lfsr_cur, lfsr_adv;

    always_comb begin
        lfsr_cur = restart ? SEED : lfsr_q;
        lfsr_adv = {lfsr_cur[0] ^ lfsr_cur[2] ^ lfsr_cur[3] ^ lfsr_cur[5], lfsr_cur[15:1]};
        fill_bit = lfsr_cur[0];
        lfsr_d   = lfsr_q;
        if ((state_q == IDLE) && start) begin
            lfsr_d = SEED;
        end else if (emit) begin
            // The sequence only advances on filler bits so template slots do not
            // shift the filler pattern.
            lfsr_d = in_tmpl ? lfsr_cur : lfsr_adv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    logic seed_unused;
    assign seed_unused = ^SEED;
    assign fill_bit    = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        bit_idx_d     = bit_idx_q;
        blk_idx_d     = blk_idx_q;
        cnt_lat_d     = cnt_lat_q;
        busy_d        = busy_q;
        rand_d        = 1'b0;
        valid_d       = 1'b0;
        block_start_d = 1'b0;
        frame_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    bit_idx_d = '0;
                    blk_idx_d = '0;
                    cnt_lat_d = cnt_sat;
                    busy_d    = 1'b1;
                end
            end
            RUN: begin
                if (!emit) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (restart) begin
                        cnt_lat_d = cnt_sat;
                    end
                    rand_d        = in_tmpl ? tmpl_bit : fill_bit;
                    valid_d       = 1'b1;
                    block_start_d = (bit_idx_q == '0);
                    frame_done_d  = last_bit;
                    if (bit_idx_q == BW'(M - 1)) begin
                        bit_idx_d = '0;
                        blk_idx_d = last_bit ? '0 : blk_idx_q + KW'(1);
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_idx_q     <= '0;
            blk_idx_q     <= '0;
            cnt_lat_q     <= '0;
            rand_q        <= 1'b0;
            valid_q       <= 1'b0;
            block_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            blk_idx_q     <= blk_idx_d;
            cnt_lat_q     <= cnt_lat_d;
            rand_q        <= rand_d;
            valid_q       <= valid_d;
            block_start_q <= block_start_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
        end
    end

    assign rand_bit    = rand_q;
    assign valid       = valid_q;
    assign block_start = block_start_q;
    assign frame_done  = frame_done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_template_stream_gen.sv
// tb/tb_template_stream_gen.sv - scoreboard bench for template_stream_gen
module tb_template_stream_gen;
    localparam int N     = 8;
    localparam int M     = 256;
    localparam int FRAME = N * M;
    localparam int SLOTS = M / 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] inject_cnt;
    logic       rand_bit;
    logic       valid;
    logic       block_start;
    logic       frame_done;
    logic       busy;

    int         checks    = 0;
    int         errors    = 0;
    int         bits_seen = 0;
    int         run_len   = 0;
    int         base;
    int         g;
    logic [2:0] exp_q[$];
    int         run_q[$];
    logic [2:0] mon_e;

    always #5 clk = ~clk;

    template_stream_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .inject_cnt (inject_cnt),
        .rand_bit   (rand_bit),
        .valid      (valid),
        .block_start(block_start),
        .frame_done (frame_done),
        .busy       (busy)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
        end
    endtask

    // Expected frame: {rand, block_start, frame_done} for every bit, from the slot rules.
    task automatic push_frame(input int c);
        logic [3:0] tmpl;
        int         eff;
        int         b;
        int         s;
        int         o;
        logic       bit_v;
        tmpl = 4'b1100;
        eff  = (c > SLOTS) ? SLOTS : c;
        for (int p = 0; p < FRAME; p++) begin
            b     = p % M;
            s     = b / 8;
            o     = b % 8;
            bit_v = (s < eff && o < 4) ? tmpl[3 - o] : 1'b0;
            exp_q.push_back({bit_v, (b == 0), (p == FRAME - 1)});
        end
    endtask

    // Monitor: pops one expectation per valid bit and records lengths of valid runs.
    always @(posedge clk) begin
        #1;
        if (valid === 1'b1) begin
            bits_seen++;
            run_len++;
            if (exp_q.size() == 0) begin
                check($sformatf("unexpected_bit@%0d", bits_seen), 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("bit_stream@%0d", bits_seen),
                      32'({busy, rand_bit, block_start, frame_done}), 32'({1'b1, mon_e}));
            end
        end else if (run_len != 0) begin
            run_q.push_back(run_len);
            run_len = 0;
        end
    end

    task automatic start_frame(input int c);
        @(negedge clk);
        inject_cnt = 6'(c);
        start      = 1'b1;
        push_frame(c);
        @(posedge clk);
        #1;
        check("accept_busy_no_valid", 32'({busy, valid}), 32'b10);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("first_bit_latency", 32'({valid, block_start}), 32'b11);
    endtask

    task automatic finish_run(input string nm, input int exp_len);
        int w;
        w = 0;
        while ((valid !== 1'b0 || busy !== 1'b0) && w < 3 * FRAME) begin
            @(posedge clk);
            #1;
            w++;
        end
        check({nm, "_idle"}, 32'({valid, busy}), 32'd0);
        @(negedge clk);
        if (run_q.size() == 0) begin
            check({nm, "_run_len"}, 32'd0, 32'(exp_len));
        end else begin
            check({nm, "_run_len"}, 32'(run_q.pop_front()), 32'(exp_len));
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        inject_cnt = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({rand_bit, valid, block_start, frame_done, busy}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_reset", 32'({rand_bit, valid, block_start, frame_done, busy}), 32'd0);

        start_frame(16);
        finish_run("frame_16", FRAME);
        start_frame(0);
        finish_run("frame_0", FRAME);
        start_frame(40);
        finish_run("frame_40", FRAME);
        for (int i = 0; i < 3; i++) begin
            start_frame(int'($urandom_range(0, 63)));
            finish_run("frame_rand", FRAME);
        end

        // start mid-frame is ignored: same length, same count
        start_frame(16);
        repeat (700) @(negedge clk);
        inject_cnt = 6'd5;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_run("mid_start", FRAME);

        // start held: two chained frames, count change takes effect on the second
        @(negedge clk);
        inject_cnt = 6'd16;
        start      = 1'b1;
        push_frame(16);
        push_frame(4);
        base = bits_seen;
        g    = 0;
        while (bits_seen < base + 1000 && g < 2 * FRAME) begin
            @(negedge clk);
            g++;
        end
        inject_cnt = 6'd4;
        g = 0;
        while (frame_done !== 1'b1 && g < 3 * FRAME) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("chain_first_done", 32'(frame_done), 32'd1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        finish_run("chain", 2 * FRAME);

        // reset at bit 1000 aborts the frame
        base = bits_seen;
        start_frame(16);
        g = 0;
        while (bits_seen < base + 1000 && g < 2 * FRAME) begin
            @(negedge clk);
            g++;
        end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("reset_midframe", 32'({rand_bit, valid, block_start, frame_done, busy}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        finish_run("reset_abort", 1000);
        start_frame(16);
        finish_run("after_reset", FRAME);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/template_stream_gen.md
# template_stream_gen

Known-answer bitstream source for the non-overlapping template test path. On `start` it emits one frame of N blocks of M bits, one bit per clock, in which the 4-bit template B is placed a programmed number of times per block at fixed non-overlapping slots. It drives the same serial `rand` interface the template checker consumes, so match counts and pass/fail results are predictable in self-test and in simulation.

## Interface
- `N`, 8, blocks per frame
- `M`, 256, bits per block; must be a multiple of 8
- `TM`, 4, template length in bits
- `B`, 4'b1100, template pattern; the MSB is emitted first
- `SEED`, 16'hACE1, LFSR reset/reload value; must be nonzero. Used only with `TSG_LFSR_FILL_EN`.
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: frame request; sampled only in IDLE or on the last bit of a frame
- `inject_cnt` in 6: templates per block; latched at frame start; values above M/8 saturate to M/8
- `rand` out 1: serial bit, registered
- `valid` out 1: high while `rand` carries a frame bit
- `block_start` out 1: high with the first bit of each block
- `frame_done` out 1: one-cycle pulse with the last bit of a frame
- `busy` out 1: high from the cycle after an accepted `start` through the last bit

## Operation
- States:
  - IDLE: outputs quiet, waiting for `start`.
  - RUN: emitting bits.
- Transitions:
  - IDLE→RUN on `start`=1.
  - RUN→IDLE after bit N·M−1, unless `start`=1 on that cycle. In that case RUN continues with a new frame, the bit counter returns to 0, and `inject_cnt` is re-latched.
- Counters:
  - `bit_idx` is a log2(M)-bit position within the block.
  - `blk_idx` is a 3-bit block number.
  - Both wrap at M−1 and N−1 respectively.
- Slots: the block is divided into M/8 slots of 8 bits. Slot s covers bits 8s..8s+7.
- Bit selection:
  - For slots s < `cnt_lat`, bits 8s..8s+3 are B[3], B[2], B[1], B[0].
  - All other bits are filler.
- Filler is 0 unless `TSG_LFSR_FILL_EN` is defined.
- With zero filler, each block contains exactly `cnt_lat` non-overlapping occurrences of B. The 4-bit zero gap after each template prevents cross-slot matches for B=1100.
- Saturation: `cnt_lat` = min(`inject_cnt`, M/8). With defaults, 40 becomes 32.
- `start` while RUN and not on the last bit is ignored.

## Timing
- Reset values:
  - `rand`, `valid`, `block_start`, `frame_done`, `busy` = 0.
  - State = IDLE, counters = 0, `cnt_lat` = 0, LFSR = `SEED`.
- Latency: `start` sampled high at edge k gives the first bit (block 0, bit 0) with `valid`=1 and `block_start`=1 after edge k+1.
- Throughput: bits are continuous, with `valid` high for exactly N·M consecutive cycles per frame and no gaps between back-to-back frames.
- `block_start` is high on bits 0, M, 2M, …; that is N pulses per frame.
- `frame_done` coincides with the bit N·M−1. In the next cycle `valid`=0, unless a frame chains.
- Reset mid-frame: the next edge forces the reset values. No partial frame resumes.

## Configuration
- `TSG_LFSR_FILL_EN` defined:
  - Filler bits come from a 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, which advances only on filler bits.
  - The LFSR reloads `SEED` at every frame start, so each frame is repeatable.
  - The match count per block becomes ≥ `cnt_lat`.
- Not defined: filler is constant 0 and no LFSR is instantiated.

## Test plan
- Reset, then `start` pulse with `inject_cnt`=16 and zero filler -> `valid` high for exactly 2048 cycles starting 1 cycle after `start`. Each block holds 16 occurrences of 1100, located at bit offsets 0, 8, …, 120, and bits 128..255 are 0. There are 8 `block_start` pulses and 1 `frame_done` pulse on cycle 2048.
- `inject_cnt`=0 -> all 2048 bits are 0. `inject_cnt`=40 -> saturates to 32 templates per block, and every slot starts with 1100.
- `start` held high continuously -> frames chain with no idle cycle, and `block_start` stays periodic at 256. Change `inject_cnt` mid-frame from 16 to 4 -> the current frame keeps 16 per block and the next frame has 4.
- Assert `rst` at bit 1000 -> the next cycle shows `valid`=`busy`=`rand`=0 and IDLE. A subsequent `start` produces a clean frame from bit 0.
- With `TSG_LFSR_FILL_EN`, two frames with `inject_cnt`=8 -> the two bit sequences are identical. Template slots still read 1100 at offsets 0..56.
- `start` pulse in the middle of RUN -> no effect: the frame length stays 2048 and `cnt_lat` is unchanged.
